// File: rtl/sonata_usb_fifo_regs.sv
// sonata_usb_fifo_regs
// Register slave behind the USB register front-end, usb_clk domain only.
// Holds ID / CTRL / STATUS / COUNT registers and a byte FIFO that an
// on-chip producer fills and the host drains through FIFO_DATA.
//
// Ports:
//   usb_clk      sole clock
//   rst          asynchronous active-high reset
//   reg_address  register select (upper address bits)
//   reg_bytecnt  byte within the selected register
//   reg_datao    host write data
//   reg_read     host read strobe (level)
//   reg_write    host write strobe (level)
//   reg_datai    registered read data (1-cycle latency)
//   in_data      producer byte
//   in_valid     producer byte strobe, no back-pressure
//   capture_en   registered copy of CTRL.enable for the producer
module sonata_usb_fifo_regs #(
    parameter int          pADDR_WIDTH   = 21,
    parameter int          pBYTECNT_SIZE = 7,
    parameter int          pFIFO_AW      = 9,
    parameter logic [31:0] pID           = 32'h534F_4E31
) (
    input  logic                                 usb_clk,
    input  logic                                 rst,
    input  logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
    input  logic [pBYTECNT_SIZE-1:0]             reg_bytecnt,
    input  logic [7:0]                           reg_datao,
    input  logic                                 reg_read,
    input  logic                                 reg_write,
    output logic [7:0]                           reg_datai,
    input  logic [7:0]                           in_data,
    input  logic                                 in_valid,
    output logic                                 capture_en
);

    localparam int RA_W  = pADDR_WIDTH - pBYTECNT_SIZE;
    localparam int DEPTH = 1 << pFIFO_AW;

    localparam logic [RA_W-1:0] A_ID    = RA_W'(0);
    localparam logic [RA_W-1:0] A_CTRL  = RA_W'(1);
    localparam logic [RA_W-1:0] A_STAT  = RA_W'(2);
    localparam logic [RA_W-1:0] A_COUNT = RA_W'(3);
    localparam logic [RA_W-1:0] A_FIFO  = RA_W'(4);
    localparam logic [RA_W-1:0] A_FLG   = RA_W'(5);

    localparam logic [pBYTECNT_SIZE-1:0] B0 = pBYTECNT_SIZE'(0);
    localparam logic [pBYTECNT_SIZE-1:0] B1 = pBYTECNT_SIZE'(1);
    localparam logic [pBYTECNT_SIZE-1:0] B2 = pBYTECNT_SIZE'(2);
    localparam logic [pBYTECNT_SIZE-1:0] B3 = pBYTECNT_SIZE'(3);

    localparam logic [pFIFO_AW:0]   CNT_ZERO = {(pFIFO_AW+1){1'b0}};
    localparam logic [pFIFO_AW:0]   CNT_ONE  = {{pFIFO_AW{1'b0}}, 1'b1};
    localparam logic [pFIFO_AW:0]   CNT_FULL = {1'b1, {pFIFO_AW{1'b0}}};
    localparam logic [pFIFO_AW-1:0] PTR_ZERO = {pFIFO_AW{1'b0}};
    localparam logic [pFIFO_AW-1:0] PTR_ONE  = {{(pFIFO_AW-1){1'b0}}, 1'b1};

    logic [7:0] mem_r [DEPTH];

    logic [pFIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [pFIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [pFIFO_AW:0]   count_q,  count_d;
    logic                enable_q, enable_d;
    logic                ovf_q,    ovf_d;
    logic                unf_q,    unf_d;
    logic                armed_q,  armed_d;
    logic                read_q,   write_q;
    logic [7:0]          head_q,   head_d;
    logic [7:0]          datai_q,  datai_d;

    logic        empty_s, full_s;
    logic        rd_rise_s, rd_fall_s, wr_rise_s;
    logic        ctrl_sel_s, flg_sel_s, flush_s;
    logic        pop_req_s, pop_s, push_s, in_try_s;
    logic        ovf_set_s, unf_set_s;
    logic [15:0] cnt_ext_s;
    logic        unused_s;

    assign empty_s    = (count_q == CNT_ZERO);
    assign full_s     = (count_q == CNT_FULL);
    assign rd_rise_s  = reg_read & ~read_q;
    assign rd_fall_s  = ~reg_read & read_q;
    assign wr_rise_s  = reg_write & ~write_q;
    assign ctrl_sel_s = (reg_address == A_CTRL) && (reg_bytecnt == B0);
    assign flg_sel_s  = (reg_address == A_FLG) && (reg_bytecnt == B0);
    assign flush_s    = wr_rise_s & ctrl_sel_s & reg_datao[1];
    // armed_q records that this strobe started on FIFO_DATA; one pop per strobe
    assign pop_req_s  = rd_fall_s & armed_q;
    assign pop_s      = pop_req_s & ~empty_s & ~flush_s;
    assign in_try_s   = in_valid & enable_q;
    // a same-cycle pop frees a slot, so a push into a full FIFO is accepted
    assign push_s     = in_try_s & (~full_s | pop_s) & ~flush_s;
    assign ovf_set_s  = in_try_s & full_s & ~pop_s;
    assign unf_set_s  = pop_req_s & empty_s;
    assign cnt_ext_s  = 16'(count_q);
    assign unused_s   = ^{reg_datao[7:2]};

    assign reg_datai  = datai_q;
    assign capture_en = enable_q;

    // Pointer/count next state; flush overrides any push or pop
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_s) begin
            rd_ptr_d = PTR_ZERO;
            wr_ptr_d = PTR_ZERO;
            count_d  = CNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Control, flags and read-strobe tracking; a flag set beats a same-cycle clear
    always_comb begin
        enable_d = enable_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        armed_d  = armed_q;
        if (reg_write && ctrl_sel_s) begin
            enable_d = reg_datao[0];
        end else begin
            enable_d = enable_q;
        end
        if (ovf_set_s) begin
            ovf_d = 1'b1;
        end else if (reg_write && flg_sel_s && reg_datao[0]) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
        if (unf_set_s) begin
            unf_d = 1'b1;
        end else if (reg_write && flg_sel_s && reg_datao[1]) begin
            unf_d = 1'b0;
        end else begin
            unf_d = unf_q;
        end
        if (rd_rise_s) begin
            armed_d = (reg_address == A_FIFO);
        end else if (rd_fall_s) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q;
        end
    end

    // Head re-fetch from the next read pointer; bypass a push into an empty slot
    always_comb begin
        head_d = mem_r[rd_ptr_d];
        if (push_s && (wr_ptr_q == rd_ptr_d)) begin
            head_d = in_data;
        end else begin
            head_d = mem_r[rd_ptr_d];
        end
    end

    // Read-data mux, registered every cycle
    always_comb begin
        datai_d = 8'h00;
        case (reg_address)
            A_ID: begin
                case (reg_bytecnt)
                    B0:      datai_d = pID[7:0];
                    B1:      datai_d = pID[15:8];
                    B2:      datai_d = pID[23:16];
                    B3:      datai_d = pID[31:24];
                    default: datai_d = 8'h00;
                endcase
            end
            A_CTRL: begin
                if (reg_bytecnt == B0) begin
                    datai_d = {7'b0000000, enable_q};
                end else begin
                    datai_d = 8'h00;
                end
            end
            A_STAT: begin
                if (reg_bytecnt == B0) begin
                    datai_d = {4'b0000, unf_q, ovf_q, full_s, empty_s};
                end else begin
                    datai_d = 8'h00;
                end
            end
            A_COUNT: begin
                case (reg_bytecnt)
                    B0:      datai_d = cnt_ext_s[7:0];
                    B1:      datai_d = cnt_ext_s[15:8];
                    default: datai_d = 8'h00;
                endcase
            end
            A_FIFO: begin
                if ((reg_bytecnt == B0) && !empty_s) begin
                    datai_d = head_q;
                end else begin
                    datai_d = 8'h00;
                end
            end
            default: datai_d = 8'h00;
        endcase
    end

    // FIFO storage write port (no reset so it maps onto RAM)
    always_ff @(posedge usb_clk) begin
        if (push_s) begin
            mem_r[wr_ptr_q] <= in_data;
        end
    end

    // State registers; strobe history resets high so a strobe held across
    // reset release is not mistaken for a new one
    always_ff @(posedge usb_clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= PTR_ZERO;
            wr_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
            enable_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            armed_q  <= 1'b0;
            read_q   <= 1'b1;
            write_q  <= 1'b1;
            head_q   <= 8'h00;
            datai_q  <= 8'h00;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            enable_q <= enable_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            armed_q  <= armed_d;
            read_q   <= reg_read;
            write_q  <= reg_write;
            head_q   <= head_d;
            datai_q  <= datai_d;
        end
    end

endmodule
